// File: rtl/note_tone_env.sv
// Voice stage: note-pitched square tone plus an envelope-shaped PWM copy for the speaker pin.
// Build option: define ENV_ATTACK_EN for a linear attack ramp; undefined, a strike jumps to full level.
module note_tone_env #(
   parameter int unsigned HALF_W  = 17,
   parameter int unsigned ENV_DIV = 16,
   parameter int unsigned PWM_W   = 8
) (
   input  logic             CLOCK_50,
   input  logic             reset,
   input  logic [2:0]       note,
   input  logic             note_stb,
   input  logic             play,
   output logic             tone_out,
   output logic             pwm_out,
   output logic [PWM_W-1:0] level,
   output logic             busy
);

`ifdef ENV_ATTACK_EN
   typedef enum logic [1:0] {StIdle, StAttack, StSustain, StDecay} state_e;
`else
   typedef enum logic [1:0] {StIdle, StSustain, StDecay} state_e;
`endif

   localparam logic [PWM_W-1:0] LvlMax = '1;

   function automatic logic [HALF_W-1:0] half_period(input logic [2:0] n);
      logic [HALF_W-1:0] hp;
      case (n)
         3'd0: hp = HALF_W'(95556);
         3'd1: hp = HALF_W'(85131);
         3'd2: hp = HALF_W'(75843);
         3'd3: hp = HALF_W'(71586);
         3'd4: hp = HALF_W'(63776);
         3'd5: hp = HALF_W'(56818);
         3'd6: hp = HALF_W'(50619);
         3'd7: hp = HALF_W'(47778);
      endcase
      return hp;
   endfunction

   state_e              state_q, state_d;
   logic [PWM_W-1:0]    level_q, level_d;
   logic [HALF_W-1:0]   phase_q, phase_d;
   logic                tone_q, tone_d;
   logic [ENV_DIV-1:0]  tick_cnt_q;
   logic [PWM_W-1:0]    pwm_cnt_q;
   logic                tick;
   logic                strike;

   assign tick   = &tick_cnt_q;
   assign strike = note_stb & play;

   always_comb begin
      state_d = state_q;
      level_d = level_q;
      phase_d = phase_q;
      tone_d  = tone_q;

      // The note input is only sampled at a reload, so a mid-period change never cuts a half-cycle.
      if (state_q == StIdle) begin
         phase_d = half_period(note) - HALF_W'(1);
         tone_d  = 1'b0;
      end else if (phase_q == '0) begin
         phase_d = half_period(note) - HALF_W'(1);
         tone_d  = ~tone_q;
      end else begin
         phase_d = phase_q - HALF_W'(1);
      end

      unique case (state_q)
         StIdle: begin
            if (strike) begin
`ifdef ENV_ATTACK_EN
               state_d = StAttack;
`else
               state_d = StSustain;
               level_d = LvlMax;
`endif
            end
         end
`ifdef ENV_ATTACK_EN
         StAttack: begin
            if (strike) begin
               state_d = StAttack;
            end else if (!play) begin
               state_d = StDecay;
            end else if (level_q == LvlMax) begin
               state_d = StSustain;
            end else if (tick) begin
               level_d = level_q + PWM_W'(1);
               if (level_d == LvlMax) state_d = StSustain;
            end
         end
         StSustain: begin
            if (strike) state_d = StAttack;
            else if (!play) state_d = StDecay;
         end
`else
         StSustain: begin
            if (!play) state_d = StDecay;
         end
`endif
         StDecay: begin
            if (strike) begin
`ifdef ENV_ATTACK_EN
               state_d = StAttack;
`else
               state_d = StSustain;
               level_d = LvlMax;
`endif
            end else if (level_q == '0) begin
               state_d = StIdle;
               tone_d  = 1'b0;
            end else if (tick) begin
               level_d = level_q - PWM_W'(1);
               if (level_d == '0) begin
                  state_d = StIdle;
                  tone_d  = 1'b0;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q    <= StIdle;
         level_q    <= '0;
         phase_q    <= '0;
         tone_q     <= 1'b0;
         tick_cnt_q <= '0;
         pwm_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         level_q    <= level_d;
         phase_q    <= phase_d;
         tone_q     <= tone_d;
         tick_cnt_q <= tick_cnt_q + ENV_DIV'(1);
         pwm_cnt_q  <= pwm_cnt_q + PWM_W'(1);
      end
   end

   assign tone_out = tone_q;
   assign level    = level_q;
   assign busy     = (state_q != StIdle);
   assign pwm_out  = tone_q & (pwm_cnt_q < level_q);

endmodule

// File: tb/tb_note_tone_env.sv
// Self-checking bench for note_tone_env with a fast envelope tick (ENV_DIV = 2).
// The reference model tracks absolute toggle times and an envelope direction, driven by the same inputs.
module tb_note_tone_env;

   localparam int unsigned HALF_W  = 17;
   localparam int unsigned ENV_DIV = 2;
   localparam int unsigned PWM_W   = 8;
   localparam int          TICK_P  = 1 << ENV_DIV;
   localparam int          PWM_P   = 1 << PWM_W;
   localparam int          LMAX    = PWM_P - 1;
`ifdef ENV_ATTACK_EN
   localparam bit ATT = 1'b1;
`else
   localparam bit ATT = 1'b0;
`endif
   localparam int RETRIG_LVL = ATT ? 100 : LMAX;
   localparam int RETRIG_UPS = ATT ? 155 : 0;
   localparam int STRIKE_LVL = ATT ? 0 : LMAX;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [2:0]       note = 3'd0;
   logic             note_stb = 1'b0;
   logic             play = 1'b0;
   logic             tone_out, pwm_out, busy;
   logic [PWM_W-1:0] level;

   int n_checks = 0;
   int n_pass   = 0;

   note_tone_env #(.HALF_W(HALF_W), .ENV_DIV(ENV_DIV), .PWM_W(PWM_W)) dut (
      .CLOCK_50 (clk),
      .reset    (reset),
      .note     (note),
      .note_stb (note_stb),
      .play     (play),
      .tone_out (tone_out),
      .pwm_out  (pwm_out),
      .level    (level),
      .busy     (busy)
   );

   always #10 clk = ~clk;

   function automatic int hp_of(input logic [2:0] n);
      case (n)
         3'd0: return 95556;
         3'd1: return 85131;
         3'd2: return 75843;
         3'd3: return 71586;
         3'd4: return 63776;
         3'd5: return 56818;
         3'd6: return 50619;
         default: return 47778;
      endcase
   endfunction

   // Model state: dir is +1 ramping, 0 holding, -1 fading; toggles happen at absolute edge m_next.
   int m_t = 0, m_cyc = 0, m_level = 0, m_dir = 0, m_next = 0;
   bit m_tone = 1'b0, m_active = 1'b0;

   always @(posedge clk) begin : model
      int lv, dr, nt;
      bit act, tn, tk, stk;
      lv = m_level; dr = m_dir; nt = m_next; act = m_active; tn = m_tone;
      tk  = (m_cyc % TICK_P) == TICK_P - 1;
      stk = note_stb && play;
      if (reset) begin
         lv = 0; dr = 0; act = 1'b0; tn = 1'b0;
         m_cyc <= 0;
      end else begin
         m_cyc <= m_cyc + 1;
         if (act && m_t == nt) begin
            tn = !tn;
            nt = m_t + hp_of(note);
         end
         if (stk) begin
            if (!act) begin
               act = 1'b1;
               nt  = m_t + hp_of(note);
               lv  = STRIKE_LVL;
               dr  = ATT ? 1 : 0;
            end else if (ATT) begin
               dr = 1;
            end else begin
               lv = LMAX;
               dr = 0;
            end
         end else if (act && !play && dr >= 0) begin
            dr = -1;
         end else if (dr == 1) begin
            if (lv == LMAX) dr = 0;
            else if (tk) begin
               lv = lv + 1;
               if (lv == LMAX) dr = 0;
            end
         end else if (dr == -1) begin
            if (lv == 0) begin
               act = 1'b0; tn = 1'b0; dr = 0;
            end else if (tk) begin
               lv = lv - 1;
               if (lv == 0) begin
                  act = 1'b0; tn = 1'b0; dr = 0;
               end
            end
         end
      end
      m_t      <= m_t + 1;
      m_level  <= lv;
      m_dir    <= dr;
      m_next   <= nt;
      m_active <= act;
      m_tone   <= tn;
   end

   logic [PWM_W+2:0] obs_vec, exp_vec;
   assign obs_vec = {tone_out, pwm_out, busy, level};
   assign exp_vec = {m_tone, m_tone & ((m_cyc % PWM_P) < m_level), m_active, PWM_W'(m_level)};

   task automatic test_reset();
      note = 3'($urandom_range(0, 7));
      play = 1'b1;
      note_stb = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (obs_vec !== '0) $display("FAIL reset_hold cyc=%0d got=%h want=0", i, obs_vec);
         else n_pass++;
         n_checks++;
         note_stb = ~note_stb;
      end
      reset = 1'b0;
      play = 1'b0;
      note_stb = 1'b0;
   endtask

   task automatic test_ignored_strike();
      note = 3'($urandom_range(0, 7));
      note_stb = 1'b1;
      @(negedge clk);
      note_stb = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (busy !== 1'b0) $display("FAIL ignored_strike busy=%b want=0", busy);
         else n_pass++;
         n_checks++;
         @(negedge clk);
      end
   endtask

   task automatic test_strike_pitch();
      logic [2:0] n, n2;
      int hp, chg, k;
      n   = 3'($urandom_range(5, 7));
      n2  = 3'((int'(n) + $urandom_range(1, 7)) % 8);
      hp  = hp_of(n);
      chg = $urandom_range(1100, hp - 1000);
      note = n; play = 1'b1; note_stb = 1'b1;
      @(negedge clk);
      note_stb = 1'b0;
      if (busy !== 1'b1 || level !== PWM_W'(STRIKE_LVL))
         $display("FAIL strike_latency busy=%b level=%0d want busy=1 level=%0d",
                  busy, level, STRIKE_LVL);
      else n_pass++;
      n_checks++;
      k = 0;
      while (tone_out !== 1'b1 && k <= hp + 20) begin
         if (obs_vec !== exp_vec) $display("FAIL pitch_step k=%0d got=%h want=%h", k, obs_vec, exp_vec);
         else n_pass++;
         n_checks++;
         if (k == 4 * LMAX + 10) begin
            if (level !== PWM_W'(LMAX)) $display("FAIL ramp_done level=%0d want=%0d", level, LMAX);
            else n_pass++;
            n_checks++;
         end
         if (k == chg) note = n2;
         @(negedge clk);
         k++;
      end
      if (k != hp) $display("FAIL first_rise clocks=%0d want=%0d (note %0d)", k, hp, n);
      else n_pass++;
      n_checks++;
   endtask

   task automatic test_pwm_sustain();
      for (int i = 0; i < 600; i++) begin
         if (obs_vec !== exp_vec) $display("FAIL pwm_sustain i=%0d got=%h want=%h", i, obs_vec, exp_vec);
         else n_pass++;
         n_checks++;
         @(negedge clk);
      end
   endtask

   task automatic test_retrigger();
      int k, ups;
      logic [PWM_W-1:0] prev;
      play = 1'b0;
      k = 0;
      while (m_level != 100 && k < 1100) begin
         @(negedge clk);
         if (obs_vec !== exp_vec) $display("FAIL decay_step k=%0d got=%h want=%h", k, obs_vec, exp_vec);
         else n_pass++;
         n_checks++;
         k++;
      end
      play = 1'b1; note_stb = 1'b1;
      @(negedge clk);
      note_stb = 1'b0;
      if (level !== PWM_W'(RETRIG_LVL) || busy !== 1'b1)
         $display("FAIL retrigger_level level=%0d busy=%b want level=%0d busy=1", level, busy, RETRIG_LVL);
      else n_pass++;
      n_checks++;
      ups = 0; k = 0;
      prev = level;
      while (level !== PWM_W'(LMAX) && k < 1000) begin
         @(negedge clk);
         if (obs_vec !== exp_vec) $display("FAIL attack_step k=%0d got=%h want=%h", k, obs_vec, exp_vec);
         else n_pass++;
         n_checks++;
         if (level == prev + PWM_W'(1)) ups++;
         prev = level;
         k++;
      end
      if (ups != RETRIG_UPS) $display("FAIL retrigger_ramp steps=%0d want=%0d", ups, RETRIG_UPS);
      else n_pass++;
      n_checks++;
   endtask

   task automatic test_decay_to_idle();
      int k, downs;
      logic [PWM_W-1:0] prev;
      repeat (8) @(negedge clk);
      prev = level;
      play = 1'b0;
      k = 0; downs = 0;
      while (busy !== 1'b0 && k < 1200) begin
         @(negedge clk);
         if (obs_vec !== exp_vec) $display("FAIL release_step k=%0d got=%h want=%h", k, obs_vec, exp_vec);
         else n_pass++;
         n_checks++;
         if (level == prev - PWM_W'(1)) downs++;
         prev = level;
         k++;
      end
      if (downs != LMAX) $display("FAIL decay_steps steps=%0d want=%0d", downs, LMAX);
      else n_pass++;
      n_checks++;
      if (obs_vec !== '0) $display("FAIL idle_silent got=%h want=0", obs_vec);
      else n_pass++;
      n_checks++;
   endtask

   task automatic test_reset_mid_note();
      note = 3'($urandom_range(0, 7));
      play = 1'b1; note_stb = 1'b1;
      @(negedge clk);
      note_stb = 1'b0;
      repeat ($urandom_range(200, 400)) begin
         @(negedge clk);
         if (obs_vec !== exp_vec) $display("FAIL pre_reset got=%h want=%h", obs_vec, exp_vec);
         else n_pass++;
         n_checks++;
      end
      reset = 1'b1;
      @(negedge clk);
      if (obs_vec !== '0) $display("FAIL reset_mid_note got=%h want=0", obs_vec);
      else n_pass++;
      n_checks++;
      reset = 1'b0; play = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (obs_vec !== exp_vec) $display("FAIL post_reset got=%h want=%h", obs_vec, exp_vec);
         else n_pass++;
         n_checks++;
      end
   endtask

   initial begin
      test_reset();
      test_ignored_strike();
      test_strike_pitch();
      test_pwm_sustain();
      test_retrigger();
      test_decay_to_idle();
      test_reset_mid_note();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
